tsm_rand_source_firstorder: RTL
===============================

# tsm_rand_source_firstorder

Fresh-randomness supplier sitting directly upstream of the first-order time-sharing AND gate. A 64-bit LFSR, seeded through a valid/ready port and warmed up for a programmable number of cycles, delivers one 5-bit word per accepted handshake. The word is split into `rand_bit[3:1]` and `rand_composable_bit[2:1]`, so the AND gate gets new masks every cycle it consumes.

## Interface
- `WARMUP_CYCLES`, 16: LFSR advances discarded after each seed load; 0 is legal.
- `REP_LIMIT`, 8: identical consecutive consumed words that trip the health check (only with `TSM_RAND_HEALTH_EN`); 2..255.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `seed_valid`  in  1  seed offered.
- `seed_ready`  out  1  constant 1 outside reset; a seed is accepted in every state.
- `seed`  in  64  LFSR seed.
- `rand_valid`  out  1  word available.
- `rand_ready`  in  1  consumer takes the word this cycle.
- `rand_bit`  out  3  masks for the AND gate, equal to word[2:0] (bit 1 of the port is word[0]).
- `rand_composable_bit`  out  2  composability masks, equal to word[4:3].
- `health_fail`  out  1  sticky health-check flag.

## Operation
- LFSR step, Fibonacci form: `nb = s[63]^s[62]^s[60]^s[59]`, then `s <= {s[62:0], nb}`.
- One advance is five steps, unrolled combinationally.
- The output word is s[4:0] of the current state.
- Both random output ports read 0 whenever `rand_valid` = 0.
- States:
  - IDLE: unseeded; `rand_valid` = 0.
  - WARMUP: one advance per cycle; a 16-bit down-counter runs from `WARMUP_CYCLES` to 0, then the block moves to RUN.
  - RUN: `rand_valid` = 1; one advance per cycle in which `rand_ready` = 1.
  - FAIL: health check tripped; only present with the macro.
- Seed accept (`seed_valid` & `seed_ready`):
  - `s <= seed`; a seed of 0 is replaced by 64'h1.
  - If `WARMUP_CYCLES` = 0 go to RUN, otherwise load the counter and go to WARMUP.
  - The repetition counter and `health_fail` are cleared.
  - Accept is legal from any state, including mid-WARMUP and mid-RUN.
- A seed accept and a rand handshake in the same cycle: the seed wins, the word on the ports is still considered consumed, and the LFSR takes the seed with no advance.
- `rand_ready` is ignored when `rand_valid` = 0.

## Timing
- Reset values: `rand_valid` = 0, `rand_bit` = 0, `rand_composable_bit` = 0, `health_fail` = 0. State = IDLE, s = 64'h1, counters = 0. `seed_ready` = 0 during reset and 1 from the first cycle after it.
- Seed accepted in cycle t:
  - `WARMUP_CYCLES` = 0: `rand_valid` = 1 at t+1 and the word is seed[4:0].
  - Otherwise: `rand_valid` = 1 at t+1+`WARMUP_CYCLES`.
- Handshake at cycle t: the next word appears at t+1, so sustained throughput is one word per cycle.
- Reseed during RUN: `rand_valid` drops at t+1 unless `WARMUP_CYCLES` = 0.
- Reset asserted mid-operation: all of the above reset values apply at the next edge.

## Configuration
- `TSM_RAND_HEALTH_EN` defined: repetition-count test on consumed words.
  - An 8-bit counter holds the length of the current run of identical consumed words; it is 1 on the first consumed word after a seed.
  - When the counter reaches `REP_LIMIT`, the next cycle enters FAIL: `health_fail` = 1 and `rand_valid` = 0.
  - FAIL is left only by reset or a new seed.
- Macro undefined: no counter and no FAIL state; `health_fail` is tied to 0.

## Structure
- Shared package `tsm_rand_pkg`:
  - state enum;
  - LFSR width 64;
  - tap constants 63/62/60/59;
  - word width 5 and the split indices 0..2 and 3..4;
  - zero-seed replacement 64'h1.
- One sub-module, `tsm_lfsr64_step5`: purely combinational five-step advance (64-bit in, 64-bit out). It is reused by later higher-order randomness sources.

## Test plan
- Reset, then 5 idle cycles → `rand_valid` = 0, `seed_ready` = 1, `health_fail` = 0, both random ports 0.
- `WARMUP_CYCLES` = 0, seed 64'h1, `rand_ready` = 1 → at t+1 `rand_bit` = 3'b001 and `rand_composable_bit` = 0; next word 0 (s = 64'h20).
- `WARMUP_CYCLES` = 16, arbitrary seed → `rand_valid` rises exactly 17 cycles after accept. The word stream must match the bench reference LFSR model for 10k handshakes with random `rand_ready` stalls; the word must stay stable while stalled.
- Seed 0 → behaviour identical to seed 64'h1. A seed accept coinciding with a handshake → the new seed wins, and with `WARMUP_CYCLES` = 0 the next word is seed[4:0].
- Mid-RUN reseed at `WARMUP_CYCLES` = 16 → `rand_valid` low at t+1, high again at t+17; mid-WARMUP reset → all reset values on the next edge.
- With `TSM_RAND_HEALTH_EN`, `REP_LIMIT` = 8, `WARMUP_CYCLES` = 0, seed 64'h1, `rand_ready` held high → words are 1 followed by zeros. `health_fail` = 1 and `rand_valid` = 0 the cycle after the 8th zero word is consumed; a reseed clears both. Without the macro the same stimulus keeps `rand_valid` = 1 and `health_fail` = 0.

Source files
------------

// File: rtl/tsm_rand_pkg.sv
// Shared definitions for the time-sharing randomness sources: LFSR geometry,
// output word split and the source state machine encoding.
package tsm_rand_pkg;

    localparam int unsigned LfsrWidth = 64;

    // Fibonacci feedback taps.
    localparam int unsigned Tap0 = 63;
    localparam int unsigned Tap1 = 62;
    localparam int unsigned Tap2 = 60;
    localparam int unsigned Tap3 = 59;

    // One advance produces a fresh word, so it is as many steps as the word is wide.
    localparam int unsigned WordWidth = 5;
    localparam int unsigned RandLo    = 0;
    localparam int unsigned RandHi    = 2;
    localparam int unsigned CompLo    = 3;
    localparam int unsigned CompHi    = 4;

    localparam logic [LfsrWidth-1:0] ZeroSeedSub = 64'h1;

    typedef enum logic [1:0] {
        StIdle,
        StWarmup,
        StRun
`ifdef TSM_RAND_HEALTH_EN
        , StFail
`endif
    } state_e;

endpackage

// File: rtl/tsm_lfsr64_step5.sv
// Combinational five-step advance of the 64-bit Fibonacci LFSR.
module tsm_lfsr64_step5
    import tsm_rand_pkg::*;
(
    input  logic [LfsrWidth-1:0] s,
    output logic [LfsrWidth-1:0] s_adv
);

    always_comb begin
        s_adv = s;
        for (int i = 0; i < WordWidth; i++) begin
            s_adv = {s_adv[LfsrWidth-2:0],
                     s_adv[Tap0] ^ s_adv[Tap1] ^ s_adv[Tap2] ^ s_adv[Tap3]};
        end
    end

endmodule

// File: rtl/tsm_rand_source_firstorder.sv
// Fresh-mask supplier for the first-order time-sharing AND gate: seeded LFSR,
// warm-up, one 5-bit word per handshake. Define TSM_RAND_HEALTH_EN for the
// repetition-count health check.
module tsm_rand_source_firstorder
    import tsm_rand_pkg::*;
#(
    parameter int unsigned WARMUP_CYCLES = 16,
    parameter int unsigned REP_LIMIT     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 seed_valid,
    output logic                 seed_ready,
    input  logic [LfsrWidth-1:0] seed,
    output logic                 rand_valid,
    input  logic                 rand_ready,
    output logic [3:1]           rand_bit,
    output logic [2:1]           rand_composable_bit,
    output logic                 health_fail
);

    state_e                 state_q;
    logic [LfsrWidth-1:0]   s_q;
    logic [LfsrWidth-1:0]   s_adv;
    logic [15:0]            warm_cnt_q;
    logic                   rand_valid_q;
    logic                   seed_ready_q;
    logic [WordWidth-1:0]   word;
    logic                   seed_acc;
    logic                   take;

    tsm_lfsr64_step5 u_step (
        .s     (s_q),
        .s_adv (s_adv)
    );

    assign word     = s_q[WordWidth-1:0];
    assign seed_acc = seed_valid & seed_ready_q;
    assign take     = rand_valid_q & rand_ready;

`ifdef TSM_RAND_HEALTH_EN
    logic [7:0]           rep_cnt_q;
    logic [7:0]           rep_next;
    logic [WordWidth-1:0] last_q;
    logic                 health_fail_q;

    // A zero count means nothing consumed since the seed, so the run restarts.
    assign rep_next    = (rep_cnt_q != 8'd0 && word == last_q) ? rep_cnt_q + 8'd1 : 8'd1;
    assign health_fail = health_fail_q;
`else
    assign health_fail = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            s_q          <= ZeroSeedSub;
            warm_cnt_q   <= 16'd0;
            rand_valid_q <= 1'b0;
            seed_ready_q <= 1'b0;
`ifdef TSM_RAND_HEALTH_EN
            rep_cnt_q     <= 8'd0;
            last_q        <= '0;
            health_fail_q <= 1'b0;
`endif
        end else begin
            seed_ready_q <= 1'b1;
            if (seed_acc) begin
                // A seed beats a same-cycle handshake; the LFSR takes it unadvanced.
                s_q <= (seed == '0) ? ZeroSeedSub : seed;
                if (WARMUP_CYCLES == 0) begin
                    state_q      <= StRun;
                    rand_valid_q <= 1'b1;
                end else begin
                    state_q      <= StWarmup;
                    rand_valid_q <= 1'b0;
                    warm_cnt_q   <= 16'(WARMUP_CYCLES);
                end
`ifdef TSM_RAND_HEALTH_EN
                rep_cnt_q     <= 8'd0;
                health_fail_q <= 1'b0;
`endif
            end else begin
                unique case (state_q)
                    StWarmup: begin
                        s_q        <= s_adv;
                        warm_cnt_q <= warm_cnt_q - 16'd1;
                        if (warm_cnt_q == 16'd1) begin
                            state_q      <= StRun;
                            rand_valid_q <= 1'b1;
                        end
                    end
                    StRun: begin
                        if (take) begin
                            s_q <= s_adv;
`ifdef TSM_RAND_HEALTH_EN
                            rep_cnt_q <= rep_next;
                            last_q    <= word;
                            if (rep_next == 8'(REP_LIMIT)) begin
                                state_q       <= StFail;
                                rand_valid_q  <= 1'b0;
                                health_fail_q <= 1'b1;
                            end
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign seed_ready          = seed_ready_q;
    assign rand_valid          = rand_valid_q;
    assign rand_bit            = rand_valid_q ? word[RandHi:RandLo] : 3'b000;
    assign rand_composable_bit = rand_valid_q ? word[CompHi:CompLo] : 2'b00;

endmodule
